// File: rtl/aes_pkg.sv
// AES constants and byte-level helpers shared by the key schedule
// and the encrypt/decrypt datapaths.
package aes_pkg;

  localparam int AES_NB    = 4;
  localparam int AES128_NK = 4;
  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_FWD,
    KS_REV
  } ks_state_t;

  function automatic logic [7:0] rcon(
    input logic [3:0] i
  );
    unique case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] s;
    logic [7:0] v;
    s = a;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      v = gf_mul(v, s);
    end
    return v
      ^ {v[6:0], v[7]}
      ^ {v[5:0], v[7:6]}
      ^ {v[4:0], v[7:5]}
      ^ {v[3:0], v[7:4]}
      ^ 8'h63;
  endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Round-key stream from the inverse key schedule to the
// decrypt round pipeline.
interface inv_key_schedule_if;
  import aes_pkg::*;

  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic         rk_last_o;

  modport master (
    output rk_o,
    output rk_round_o,
    output rk_valid_o,
    output rk_last_o,
    input  rk_ready_i
  );

  modport slave (
    input  rk_o,
    input  rk_round_o,
    input  rk_valid_o,
    input  rk_last_o,
    output rk_ready_i
  );

endinterface

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel S-box lookups.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] s
);

  assign s = {
    sbox(w[31:24]),
    sbox(w[23:16]),
    sbox(w[15:8]),
    sbox(w[7:0])
  };

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: expands forward to round 10,
// then streams round keys 10..0 stepping the schedule backwards.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_i,
  input  logic         start_i,
  output logic         busy_o,
  inv_key_schedule_if.master rk
);

  if (NR != AES128_NR) begin : g_nr_check
    $error("inv_key_schedule: only NR=10 supported");
  end

  localparam logic [3:0] LAST = 4'(NR);

  ks_state_t    state, state_d;
  logic [127:0] w, w_d;
  logic [3:0]   cnt, cnt_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p3, sw_in, sw_out, t;
  logic [31:0] f0, f1, f2, f3;
  logic        rev, hs;

  assign {w0, w1, w2, w3} = w;
  assign p3 = w3 ^ w2;

  // One SubWord shared: w3 going forward, p3 going back.
  assign sw_in = (state == KS_FWD) ? w3 : p3;

  aes_sub_word u_sub (
    .w ({sw_in[23:0], sw_in[31:24]}),
    .s (sw_out)
  );

  assign t  = sw_out ^ {rcon(cnt), 24'h0};
  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign rev = (state == KS_REV);
  assign hs  = rev && rk.rk_ready_i;

  always_comb begin
    state_d = state;
    w_d     = w;
    cnt_d   = cnt;
    unique case (state)
      KS_IDLE: begin
        w_d   = '0;
        cnt_d = '0;
        if (start_i) begin
          state_d = KS_FWD;
          w_d     = key_i;
          cnt_d   = 4'd1;
        end
      end
      KS_FWD: begin
        w_d   = {f0, f1, f2, f3};
        cnt_d = cnt + 4'd1;
        if (cnt == LAST) begin
          state_d = KS_REV;
          cnt_d   = LAST;
        end
      end
      KS_REV: begin
        if (hs) begin
          if (cnt == 4'd0) begin
            state_d = KS_IDLE;
            w_d     = '0;
            cnt_d   = '0;
          end else begin
            w_d   = {w0 ^ t, w1 ^ w0, w2 ^ w1, p3};
            cnt_d = cnt - 4'd1;
          end
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= KS_IDLE;
      w     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      w     <= w_d;
      cnt   <= cnt_d;
    end
  end

  assign busy_o        = (state != KS_IDLE);
  assign rk.rk_o       = w;
  assign rk.rk_valid_o = rev;
  assign rk.rk_round_o = rev ? cnt : 4'd0;
  assign rk.rk_last_o  = rev && (cnt == 4'd0);

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Iterative AES-128 round-key generator for the decryption datapath. It takes the cipher key, expands it forward internally to round key 10, then walks the schedule backwards and streams round keys 10, 9, …, 0 over a valid/ready interface. The inverse cipher consumes keys in this order, so no 1408-bit full-key register is needed. It sits beside `KeyExpansion` and feeds the decrypt round pipeline.

## Interface
- `NR`, 10: round count. Only 10 (AES-128) is supported; any other value is an elaboration error.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_i` input 128: cipher key; word0 = `key_i[127:96]`. Sampled only on an accepted start.
- `start_i` input 1: request a new schedule. Accepted only when `busy_o`=0.
- `busy_o` output 1: high from the accepted start until the round-0 key handshake completes.
- `rk_o` output 128: current round key, same word order as `key_i`.
- `rk_round_o` output 4: round index of `rk_o` (10 down to 0).
- `rk_valid_o` output 1: `rk_o` and `rk_round_o` are valid.
- `rk_ready_i` input 1: consumer accepts the key.
- `rk_last_o` output 1: high with `rk_valid_o` when `rk_round_o`=0.

## Operation
- States:
  - IDLE: wait for start.
  - FWD: forward-expand, 10 cycles.
  - REV: emit keys and step backwards.
- IDLE → FWD on `start_i`: load `key_i` into the 4-word register w0..w3 and set cnt=1.
- FWD step, each cycle:
  - t = SubWord(RotWord(w3)) ^ {Rcon[cnt],24'h0}
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
  - cnt++. After the cnt=10 step, go to REV with rnd=10.
- REV: present w0..w3 as `rk_o` and rnd as `rk_round_o`.
- REV step, on each handshake (valid & ready) with rnd>0:
  - p3=w3^w2; p2=w2^w1; p1=w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[rnd],24'h0}
  - load p0..p3 and decrement rnd.
- REV → IDLE on the handshake with rnd=0. The register is cleared to 0 in IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. All arithmetic is GF(2) XOR with no carries.
- One shared SubWord instance is muxed between the FWD input (w3) and the REV input (p3).
- `start_i` is ignored while `busy_o`=1. An in-flight schedule is never restarted or corrupted.
- `key_i` changes while busy have no effect.

## Timing
- Reset values: `busy_o`=0, `rk_valid_o`=0, `rk_last_o`=0, `rk_o`=0, `rk_round_o`=0, state=IDLE. Reset takes effect immediately, including mid-FWD or mid-REV.
- Start accepted at edge E0. `busy_o`=1 after E0. `rk_valid_o` rises after E10, so the first key is 10 cycles after acceptance.
- With `rk_ready_i` held high, one key is delivered per cycle: 11 consecutive handshakes. Total is 21 cycles from the start edge to `busy_o`=0.
- Backpressure: while valid & !ready, `rk_o`, `rk_round_o` and `rk_last_o` hold stable. Valid never drops without a handshake.
- `busy_o` falls on the edge of the final handshake. A start asserted in the same cycle is not accepted; it is accepted at the earliest on the next cycle.
- Outputs are registered only; there is no combinational path from `rk_ready_i` to `rk_o`.

## Structure
- Package `aes_pkg`:
  - constants `AES_NB`=4, `AES128_NK`=4, `AES128_NR`=10
  - Rcon table function
  - S-box function, shared with the encrypt path
- Sub-module `aes_sub_word`: 32-bit combinational SubWord (four S-box lookups). RotWord and Rcon stay in the parent.
- Single always block for the FSM/counter; combinational step logic is kept separate.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ready held high: first key d014f9a8c9ee2589e13f0cc8b6630ca6 at round 10, the next ac7766f3 19fadc21 28d12941 575c006e at round 9, a0fafe1788542cb123a339392a6c7605 at round 1, and the last is the original key with `rk_last_o`=1. Exactly 11 handshakes, then `busy_o`=0.
- All-zero key: round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, round 1 = 62636363 repeated 4×, round 0 = 0.
- Random stalls (ready low 0–5 cycles) on the FIPS key: the output sequence is identical to the previous run, and data is stable during every stall.
- `start_i` pulsed mid-REV with a different key: ignored; the sequence completes with the original keys.
- `rst_n` asserted during FWD and again during REV (cycle 5 of stalls): all outputs are 0 immediately. A restart afterwards gives the correct FIPS sequence.
- Cross-check on 100 random keys: the reversed output equals `KeyExpansion` (Nk=4, Nr=10) round keys read back to front.
